// File: rtl/adc_fifo_wr_framer.sv
// adc_fifo_wr_framer
//   Sits behind the ADC acquisition controller in the adc_clk domain and
//   writes its header/data/checksum word stream into the DDR3 write FIFO.
//   It tracks fill framing (1 header, N data words, 1 checksum) and folds the
//   data words into a 32-bit XOR checksum. The source cannot be stalled, so
//   FIFO overflow and stray words are flagged rather than back-pressured.
//
//   Optional: define ADC_FIFO_WR_CSUM_CHECK_EN to compare the checksum word's
//   low 32 bits against the accumulated fold. Without it, checksum_err is 0.
//
// Ports
//   clk             adc_clk, rising edge
//   rst_n           synchronous active-low reset
//   acq_enabled     arms the framer (low = idle/readout)
//   num_fill_bursts bursts in this fill, sampled with the header
//   in_dat/in_valid incoming word stream
//   fifo_full       DDR3 write FIFO full
//   fifo_din/fifo_wr_en  FIFO write port, one cycle behind the input
//   fill_done       one-cycle pulse per completed fill
//   fill_word_cnt   words of the last fill (header + data + checksum)
//   fill_checksum   folded XOR of the last fill's data words
//   checksum_err    last fill's checksum mismatch
//   overflow        sticky: a word was dropped on fifo_full
//   drop_cnt        dropped words, saturating
//   frame_err       sticky: in_valid seen while idle
//   wr_idle         framer is idle
module adc_fifo_wr_framer #(
  parameter int WORDS_PER_BURST = 1,
  parameter int DROP_CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acq_enabled,
  input  logic [20:0]           num_fill_bursts,
  input  logic [127:0]          in_dat,
  input  logic                  in_valid,
  input  logic                  fifo_full,
  output logic [127:0]          fifo_din,
  output logic                  fifo_wr_en,
  output logic                  fill_done,
  output logic [22:0]           fill_word_cnt,
  output logic [31:0]           fill_checksum,
  output logic                  checksum_err,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  frame_err,
  output logic                  wr_idle
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE} state_t;

  localparam logic [22:0] WPB = 23'(WORDS_PER_BURST);

  state_t      state;
  logic [22:0] expected;
  logic [22:0] word_cnt;
  logic [31:0] acc;
  logic [22:0] hdr_exp;
  logic [31:0] fold;
  logic        accept;
  logic        take_hdr;

  // Max 2^21-1 bursts * 4 words fits in 23 bits, so no overflow here.
  assign hdr_exp  = {2'b00, num_fill_bursts} * WPB;
  assign fold     = in_dat[127:96] ^ in_dat[95:64] ^ in_dat[63:32] ^ in_dat[31:0];
  assign accept   = in_valid && (state != S_IDLE);
  // DONE doubles as HDR so a header arriving right after a checksum is not lost.
  assign take_hdr = in_valid && (state == S_HDR || state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      expected      <= '0;
      word_cnt      <= '0;
      acc           <= '0;
      fifo_din      <= '0;
      fifo_wr_en    <= 1'b0;
      fill_done     <= 1'b0;
      fill_word_cnt <= '0;
      fill_checksum <= '0;
      overflow      <= 1'b0;
      drop_cnt      <= '0;
      frame_err     <= 1'b0;
      wr_idle       <= 1'b1;
    end else begin
      fifo_wr_en <= 1'b0;
      fill_done  <= 1'b0;

      // Dropped words still count toward framing; they are only flagged.
      if (accept) begin
        fifo_din   <= in_dat;
        fifo_wr_en <= ~fifo_full;
        if (fifo_full) begin
          overflow <= 1'b1;
          if (drop_cnt != {DROP_CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
        end
      end

      if (take_hdr) begin
        acc      <= '0;
        word_cnt <= 23'd1;
        expected <= hdr_exp;
        state    <= (hdr_exp == '0) ? S_CSUM : S_DATA;
      end

      case (state)
        S_IDLE: begin
          if (in_valid) frame_err <= 1'b1;
          if (acq_enabled) begin
            state   <= S_HDR;
            wr_idle <= 1'b0;
          end
        end
        S_HDR: begin
          if (!in_valid && !acq_enabled) begin
            state   <= S_IDLE;
            wr_idle <= 1'b1;
          end
        end
        S_DATA: begin
          if (in_valid) begin
            acc      <= acc ^ fold;
            expected <= expected - 23'd1;
            word_cnt <= word_cnt + 23'd1;
            if (expected == 23'd1) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (in_valid) begin
            word_cnt <= word_cnt + 23'd1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          fill_done     <= 1'b1;
          fill_word_cnt <= word_cnt;
          fill_checksum <= acc;
          if (!in_valid) begin
            if (acq_enabled) begin
              state <= S_HDR;
            end else begin
              state   <= S_IDLE;
              wr_idle <= 1'b1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          wr_idle <= 1'b1;
        end
      endcase
    end
  end

`ifdef ADC_FIFO_WR_CSUM_CHECK_EN
  logic csum_mis;

  // Mismatch captured with the checksum word, published in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_mis     <= 1'b0;
      checksum_err <= 1'b0;
    end else begin
      if (state == S_CSUM && in_valid) csum_mis <= (in_dat[31:0] != acc);
      if (state == S_DONE) checksum_err <= csum_mis;
    end
  end
`else
  assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_fifo_wr_framer.sv
module tb_adc_fifo_wr_framer;

  localparam int WPB = 1;
  localparam int DW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          acq_enabled = 1'b0;
  logic [20:0]   num_fill_bursts = '0;
  logic [127:0]  in_dat = '0;
  logic          in_valid = 1'b0;
  logic          fifo_full = 1'b0;
  logic [127:0]  fifo_din;
  logic          fifo_wr_en;
  logic          fill_done;
  logic [22:0]   fill_word_cnt;
  logic [31:0]   fill_checksum;
  logic          checksum_err;
  logic          overflow;
  logic [DW-1:0] drop_cnt;
  logic          frame_err;
  logic          wr_idle;

  adc_fifo_wr_framer #(.WORDS_PER_BURST(WPB), .DROP_CNT_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .acq_enabled(acq_enabled),
    .num_fill_bursts(num_fill_bursts), .in_dat(in_dat), .in_valid(in_valid),
    .fifo_full(fifo_full), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fill_done(fill_done), .fill_word_cnt(fill_word_cnt),
    .fill_checksum(fill_checksum), .checksum_err(checksum_err),
    .overflow(overflow), .drop_cnt(drop_cnt), .frame_err(frame_err),
    .wr_idle(wr_idle)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fold(input logic [127:0] d);
    return d[127:96] ^ d[95:64] ^ d[63:32] ^ d[31:0];
  endfunction

  // Behavioural model: a fill is "header, then expected+1 more words".
  // m_left = words still owed to the current fill (0 = waiting for header),
  // m_donep = the previous word closed a fill, so status is published now.
  bit            m_idle = 1'b1;
  int            m_left = 0;
  bit            m_donep = 1'b0;
  logic [22:0]   m_cnt = '0;
  logic [31:0]   m_acc = '0;
  bit            m_mis = 1'b0;
  logic          e_wr_en = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic          e_ovf = 1'b0, e_ferr = 1'b0, e_idle = 1'b1;
  logic [127:0]  e_din = '0;
  logic [22:0]   e_cnt = '0;
  logic [31:0]   e_chk = '0;
  logic [DW-1:0] e_drop = '0;

  task automatic model_step();
    if (!rst_n) begin
      m_idle = 1'b1; m_left = 0; m_donep = 1'b0; m_cnt = '0; m_acc = '0; m_mis = 1'b0;
      e_wr_en = 1'b0; e_done = 1'b0; e_err = 1'b0; e_ovf = 1'b0; e_ferr = 1'b0;
      e_din = '0; e_cnt = '0; e_chk = '0; e_drop = '0; e_idle = 1'b1;
      return;
    end
    e_wr_en = 1'b0;
    e_done  = 1'b0;
    if (m_idle) begin
      if (in_valid) e_ferr = 1'b1;
      if (acq_enabled) begin
        m_idle = 1'b0; m_left = 0; m_donep = 1'b0;
      end
    end else begin
      if (in_valid) begin
        e_din   = in_dat;
        e_wr_en = !fifo_full;
        if (fifo_full) begin
          e_ovf = 1'b1;
          if (e_drop != {DW{1'b1}}) e_drop = e_drop + 1'b1;
        end
      end
      if (m_donep) begin
        e_done = 1'b1; e_cnt = m_cnt; e_chk = m_acc;
`ifdef ADC_FIFO_WR_CSUM_CHECK_EN
        e_err = m_mis;
`else
        e_err = 1'b0;
`endif
        m_donep = 1'b0;
      end
      if (m_left == 0) begin
        if (in_valid) begin
          m_left = int'(num_fill_bursts) * WPB + 1;
          m_cnt  = 23'd1;
          m_acc  = '0;
        end else if (!acq_enabled) begin
          m_idle = 1'b1;
        end
      end else if (in_valid) begin
        m_cnt = m_cnt + 23'd1;
        if (m_left > 1) m_acc = m_acc ^ fold(in_dat);
        else begin
          m_mis   = (in_dat[31:0] != m_acc);
          m_donep = 1'b1;
        end
        m_left--;
      end
    end
    e_idle = m_idle;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("fifo_wr_en", 128'(fifo_wr_en), 128'(e_wr_en));
    if (e_wr_en) chk("fifo_din", fifo_din, e_din);
    chk("fill_done", 128'(fill_done), 128'(e_done));
    chk("fill_word_cnt", 128'(fill_word_cnt), 128'(e_cnt));
    chk("fill_checksum", 128'(fill_checksum), 128'(e_chk));
    chk("checksum_err", 128'(checksum_err), 128'(e_err));
    chk("overflow", 128'(overflow), 128'(e_ovf));
    chk("drop_cnt", 128'(drop_cnt), 128'(e_drop));
    chk("frame_err", 128'(frame_err), 128'(e_ferr));
    chk("wr_idle", 128'(wr_idle), 128'(e_idle));
    if (fifo_wr_en) n_wr++;
    if (fill_done) n_done++;
  end

  task automatic cyc(input logic v, input logic [127:0] d, input logic full);
    in_valid = v; in_dat = d; fifo_full = full;
    @(posedge clk); #1;
    in_valid = 1'b0; fifo_full = 1'b0;
  endtask

  // Waits (bounded) for fill_done; n = negedges waited.
  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (fill_done) break;
    end
    chk(nm, 128'(fill_done), 128'(1));
    #1;
  endtask

  function automatic logic [127:0] lane_bit(input int i);
    logic [127:0] w;
    w = '0;
    w[32*i + i] = 1'b1;
    return w;
  endfunction

  int n, w0, d0;
  logic [127:0] d;

  initial begin
    repeat (3) cyc(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("reset wr_idle", 128'(wr_idle), 128'(1));
    chk("reset fifo_wr_en", 128'(fifo_wr_en), 128'(0));
    chk("reset fill_word_cnt", 128'(fill_word_cnt), 128'(0));
    rst_n = 1'b1;

    // Four-burst fill, lane bits fold to 0xF.
    acq_enabled = 1'b1; num_fill_bursts = 21'd4;
    cyc(1'b0, '0, 1'b0);
    w0 = n_wr;
    cyc(1'b1, {4{32'hA5A5_0001}}, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, lane_bit(i), 1'b0);
    cyc(1'b1, 128'hF, 1'b0);
    wait_done("fillA done", n);
    chk("fillA done latency", 128'(n), 128'(2));
    chk("fillA wr pulses", 128'(n_wr - w0), 128'(6));
    chk("fillA word_cnt", 128'(fill_word_cnt), 128'(6));
    chk("fillA checksum", 128'(fill_checksum), 128'(32'hF));
    chk("fillA checksum_err", 128'(checksum_err), 128'(0));

    // Empty fill: header then checksum.
    num_fill_bursts = 21'd0;
    cyc(1'b1, 128'h1234, 1'b0);
    cyc(1'b1, 128'h0, 1'b0);
    wait_done("empty done", n);
    chk("empty word_cnt", 128'(fill_word_cnt), 128'(2));
    chk("empty checksum", 128'(fill_checksum), 128'(0));

    // FIFO full on data words 2 and 3.
    num_fill_bursts = 21'd4; w0 = n_wr;
    cyc(1'b1, 128'h55, 1'b0);
    cyc(1'b1, lane_bit(0), 1'b0);
    cyc(1'b1, lane_bit(1), 1'b1);
    cyc(1'b1, lane_bit(2), 1'b1);
    cyc(1'b1, lane_bit(3), 1'b0);
    cyc(1'b1, 128'hF, 1'b0);
    wait_done("ovf done", n);
    chk("ovf overflow", 128'(overflow), 128'(1));
    chk("ovf drop_cnt", 128'(drop_cnt), 128'(2));
    chk("ovf word_cnt", 128'(fill_word_cnt), 128'(6));
    chk("ovf wr pulses", 128'(n_wr - w0), 128'(4));

    // Back-to-back fills, second header lands in the DONE cycle.
    num_fill_bursts = 21'd2; w0 = n_wr; d0 = n_done;
    for (int f = 0; f < 2; f++) begin
      cyc(1'b1, 128'hBEEF, 1'b0);
      cyc(1'b1, lane_bit(f), 1'b0);
      cyc(1'b1, lane_bit(2), 1'b0);
      cyc(1'b1, 128'(fold(lane_bit(f)) ^ 32'h4), 1'b0);
    end
    wait_done("b2b done", n);
    chk("b2b done pulses", 128'(n_done - d0), 128'(2));
    chk("b2b wr pulses", 128'(n_wr - w0), 128'(8));
    chk("b2b word_cnt", 128'(fill_word_cnt), 128'(4));
    chk("b2b checksum", 128'(fill_checksum), 128'(32'h6));

    // acq_enabled drops mid-DATA: fill completes, then idle.
    num_fill_bursts = 21'd3;
    cyc(1'b1, 128'h77, 1'b0);
    cyc(1'b1, lane_bit(0), 1'b0);
    acq_enabled = 1'b0;
    cyc(1'b1, lane_bit(1), 1'b0);
    cyc(1'b1, lane_bit(2), 1'b0);
    cyc(1'b1, 128'h7, 1'b0);
    wait_done("acqdrop done", n);
    chk("acqdrop word_cnt", 128'(fill_word_cnt), 128'(5));
    chk("acqdrop wr_idle", 128'(wr_idle), 128'(1));
    w0 = n_wr;
    cyc(1'b1, 128'hDEAD, 1'b0);
    @(negedge clk); #1;
    chk("stray frame_err", 128'(frame_err), 128'(1));
    chk("stray no write", 128'(n_wr - w0), 128'(0));

    // Reset after 3 of 8 data words.
    acq_enabled = 1'b1; num_fill_bursts = 21'd8;
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 128'h88, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, lane_bit(i), 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("rst wr_idle", 128'(wr_idle), 128'(1));
    chk("rst fifo_wr_en", 128'(fifo_wr_en), 128'(0));
    chk("rst overflow", 128'(overflow), 128'(0));
    chk("rst frame_err", 128'(frame_err), 128'(0));
    chk("rst drop_cnt", 128'(drop_cnt), 128'(0));
    chk("rst word_cnt", 128'(fill_word_cnt), 128'(0));
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0);
    num_fill_bursts = 21'd1;
    cyc(1'b1, 128'h99, 1'b0);
    cyc(1'b1, lane_bit(3), 1'b0);
    cyc(1'b1, 128'h8, 1'b0);
    wait_done("fresh done", n);
    chk("fresh word_cnt", 128'(fill_word_cnt), 128'(3));
    chk("fresh checksum", 128'(fill_checksum), 128'(32'h8));

    // Corrupted checksum (bit 0 flipped), then a good fill.
    cyc(1'b1, 128'hC0, 1'b0);
    cyc(1'b1, lane_bit(0), 1'b0);
    cyc(1'b1, 128'h0, 1'b0);
    wait_done("bad csum done", n);
`ifdef ADC_FIFO_WR_CSUM_CHECK_EN
    chk("bad csum checksum_err", 128'(checksum_err), 128'(1));
`else
    chk("bad csum checksum_err", 128'(checksum_err), 128'(0));
`endif
    cyc(1'b1, 128'hC1, 1'b0);
    cyc(1'b1, lane_bit(0), 1'b0);
    cyc(1'b1, 128'h1, 1'b0);
    wait_done("good csum done", n);
    chk("good csum checksum_err", 128'(checksum_err), 128'(0));

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      if (acq_enabled) begin
        if ($urandom_range(39) == 0) acq_enabled = 1'b0;
      end else if ($urandom_range(4) == 0) begin
        acq_enabled = 1'b1;
      end
      num_fill_bursts = 21'($urandom_range(5));
      d = {$urandom, $urandom, $urandom, $urandom};
      if (m_left == 1 && $urandom_range(1) == 0) d[31:0] = m_acc;
      cyc($urandom_range(9) < 7, d, $urandom_range(99) < 15);
    end
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
